mgmt_hub: RTL and testbench
===========================

// Module: mgmt_hub
// PURPOSE
//  Parametrised management-bus interconnect between the core mgmt master and N_SLV mgmt slaves
//  (sysreg, PIC, memory controller, MDIO, debug, ...). Decodes mgmt_adr to route each request
//  to exactly one slave and muxes read responses back through a registered path.
//  Returns a hub-generated error for unmapped addresses and, optionally, for slave timeouts.
//  Supports one outstanding transaction at a time and logs protocol errors in sticky flags.
// PARAMETERS
//  N_SLV     5             number of slave ports (1..16)
//  SEL_LSB   12            LSB of the slave-select field in mgmt_adr
//  SEL_W     4             width of the slave-select field
//  SLV_ID    {5{4'hx}}     packed N_SLV*SEL_W select values; slice i = select value of slave i
//  TMO_W     8             timeout counter width
//  TIMEOUT   255           cycles to wait for slave ack or rxe before hub error (<2**TMO_W)
//  ERR_DATA  32'hDEADBEEF  read data returned on a decode or timeout error
// PORTS
//  clk        in   1        system clock
//  rstn       in   1        asynchronous reset, active low
//  mgmt_req   in   1        master request; held high until mgmt_ack
//  mgmt_adr   in   32       master address
//  mgmt_rwn   in   1        1=read, 0=write
//  mgmt_wen   in   2        write enables
//  mgmt_txd   in   32       write data
//  mgmt_ack   out  1        request accepted (one cycle)
//  mgmt_rxe   out  1        read data valid (one cycle)
//  mgmt_rxd   out  32       read data
//  slv_req    out  N_SLV    one-hot request to the selected slave
//  slv_adr/slv_rwn/slv_wen/slv_txd  out  32/1/2/32  broadcast copies of master fields (comb.)
//  slv_ack    in   N_SLV    per-slave ack
//  slv_rxe    in   N_SLV    per-slave read-data valid
//  slv_rxd    in   N_SLV*32 per-slave read data; slice i = slave i
//  err_stat   out  3        sticky flags {stray_rxe, timeout, decerr}
//  err_clr    in   1        clears err_stat
// BEHAVIOUR
//  Reset: state=IDLE; mgmt_rxe=0, mgmt_rxd=0, err_stat=0, counter=0; slv_req=0 as soon as rstn is low.
//  Decode is combinational: hit[i] = (mgmt_adr[SEL_LSB+:SEL_W]==SLV_ID slice i); duplicate IDs -> lowest i.
//  States: IDLE, WAIT_RXD, ERR_RSP.
//  IDLE, mgmt_req=1 with hit:
//   - slv_req[sel]=1 (comb.); mgmt_ack=slv_ack[sel] (comb., zero latency); sel is latched.
//   - On ack: write -> stay IDLE; read -> WAIT_RXD. Counter counts held-req cycles and clears on ack.
//  IDLE, mgmt_req=1 with no hit: no slv_req. Next cycle go to ERR_RSP and set decerr.
//  ERR_RSP (1 cycle): mgmt_ack=1; if read, mgmt_rxe=1 and mgmt_rxd=ERR_DATA one cycle later; -> IDLE.
//  WAIT_RXD: slv_rxe[sel] at cycle t -> mgmt_rxe=1, mgmt_rxd=slv_rxd[sel] at t+1; -> IDLE.
//   - mgmt_ack=0 and slv_req=0 in this state, so a new master request stalls until the read completes.
//   - An rxe that arrives in the same cycle as the ack (slave 0-latency read) is accepted; no WAIT_RXD wait.
//  Stray rxe: slv_rxe[j] for j!=sel, or any slv_rxe outside a pending read -> ignored; stray_rxe set.
//  mgmt_rxe is a single-cycle pulse; mgmt_rxd holds its last value otherwise.
//  Counter is TMO_W bits and saturates; it never wraps.
//  err_clr and a new error in the same cycle: the set wins.
//  mgmt_req dropped before ack (protocol violation): slv_req drops with it; in WAIT_RXD the hub keeps waiting.
//  rstn asserted mid-transaction: immediate return to IDLE; the in-flight response is discarded.
// CONFIGURATION
//  MGMT_HUB_TIMEOUT_EN defined:
//   - IDLE with held req and no ack for TIMEOUT cycles -> hub drops slv_req, sets timeout, goes to ERR_RSP.
//   - WAIT_RXD with no rxe for TIMEOUT cycles -> mgmt_rxe=1, mgmt_rxd=ERR_DATA, sets timeout, -> IDLE.
//   - A slave ack/rxe that arrives after a timeout is handled as a stray rxe (ack is ignored).
//  MGMT_HUB_TIMEOUT_EN undefined: no counter logic; the hub waits indefinitely; timeout flag is tied to 0.
// TESTING
//  Write adr 0x00001004, SLV_ID slave1=1, slave acks at cycle 3 -> slv_req[1] high cycles 0-3,
//   mgmt_ack at cycle 3, no rxe, state stays IDLE.
//  Read slave 2, ack at cycle 1, rxe at cycle 4 with 0x12345678 -> mgmt_rxe=1 and mgmt_rxd=0x12345678 at cycle 5;
//   a second req issued at cycle 2 is not acked before cycle 6.
//  Read unmapped adr 0x0000F000 -> no slv_req; mgmt_ack at cycle 1; rxe with 0xDEADBEEF at cycle 2;
//   err_stat=3'b001.
//  In WAIT_RXD for slave 0, slave 3 pulses rxe -> no mgmt_rxe; err_stat[2]=1.
//   Same cycle with err_clr=1 -> err_stat[2] stays 1.
//  With TIMEOUT_EN and TIMEOUT=8, read to a silent slave -> ack at cycle 9, rxe with ERR_DATA at cycle 10,
//   err_stat[1]=1. Without the macro: no ack after 1000 cycles.
//  Assert rstn=0 during WAIT_RXD -> slv_req=0 and mgmt_rxe=0 immediately; after release a new write completes.

Source files
------------

// File: rtl/mgmt_hub.sv
// mgmt_hub: management-bus interconnect between one mgmt master and N_SLV mgmt slaves.
//
// The hub decodes mgmt_adr[SEL_LSB +: SEL_W] against SLV_ID and routes each request to exactly
// one slave. If more than one slave matches, the lowest index wins. Read data comes back through
// a registered path. An unmapped address gets a response generated by the hub itself. Only one
// transaction can be outstanding at a time. Protocol errors are recorded in sticky flags.
//
// Ports
//   clk, rstn                       system clock, asynchronous active-low reset
//   mgmt_req/adr/rwn/wen/txd        master request; req is held until mgmt_ack
//   mgmt_ack                        request accepted (one-cycle pulse, combinational)
//   mgmt_rxe/mgmt_rxd               registered read-data pulse; rxd holds its last value
//   slv_req                         one-hot request to the selected slave
//   slv_adr/rwn/wen/txd             combinational broadcast of the master fields
//   slv_ack/slv_rxe/slv_rxd         per-slave ack, read-valid and read data (slice i = slave i)
//   err_stat                        sticky {stray_rxe, timeout, decerr}; err_clr clears it
//
// Configuration
//   MGMT_HUB_TIMEOUT_EN  when defined, the hub gives up on a slave after TIMEOUT cycles,
//                        both while waiting for ack and while waiting for rxe, and answers
//                        with ERR_DATA. When undefined, there is no counter and the timeout
//                        flag is tied to 0.
module mgmt_hub #(
  parameter int unsigned            N_SLV    = 5,
  parameter int unsigned            SEL_LSB  = 12,
  parameter int unsigned            SEL_W    = 4,
  parameter logic [N_SLV*SEL_W-1:0] SLV_ID   = 20'h43210,
  parameter int unsigned            TMO_W    = 8,
  parameter int unsigned            TIMEOUT  = 255,
  parameter logic [31:0]            ERR_DATA = 32'hDEADBEEF
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                mgmt_req,
  input  logic [31:0]         mgmt_adr,
  input  logic                mgmt_rwn,
  input  logic [1:0]          mgmt_wen,
  input  logic [31:0]         mgmt_txd,
  output logic                mgmt_ack,
  output logic                mgmt_rxe,
  output logic [31:0]         mgmt_rxd,
  output logic [N_SLV-1:0]    slv_req,
  output logic [31:0]         slv_adr,
  output logic                slv_rwn,
  output logic [1:0]          slv_wen,
  output logic [31:0]         slv_txd,
  input  logic [N_SLV-1:0]    slv_ack,
  input  logic [N_SLV-1:0]    slv_rxe,
  input  logic [N_SLV*32-1:0] slv_rxd,
  output logic [2:0]          err_stat,
  input  logic                err_clr
);

  localparam int unsigned SIDX_W = (N_SLV > 1) ? $clog2(N_SLV) : 1;

  // Elaboration-time sanity check on the timeout configuration.
  if (TMO_W < 1 || TMO_W > 31 || TIMEOUT >= (32'd1 << TMO_W)) begin : g_tmo_chk
    $error("mgmt_hub: TIMEOUT must fit in TMO_W bits");
  end

  typedef enum logic [1:0] {StIdle, StWaitRxd, StErrRsp} state_e;

  state_e             state_q, state_d;
  logic [SIDX_W-1:0]  sel_q, sel_d;
  logic               rwn_q, rwn_d;
  logic               rxe_q, rxe_d;
  logic [31:0]        rxd_q, rxd_d;
  logic [2:0]         err_q, err_d;

  logic               any_hit;
  logic [SIDX_W-1:0]  hit_idx;
  logic [N_SLV-1:0]   rxe_ok;
  logic               set_dec, set_tmo;
  logic               tmo_hit;

  assign slv_adr  = mgmt_adr;
  assign slv_rwn  = mgmt_rwn;
  assign slv_wen  = mgmt_wen;
  assign slv_txd  = mgmt_txd;
  assign mgmt_rxe = rxe_q;
  assign mgmt_rxd = rxd_q;
  assign err_stat = err_q;

  // Descending scan so the lowest matching index wins on duplicate IDs.
  always_comb begin
    any_hit = 1'b0;
    hit_idx = '0;
    for (int i = int'(N_SLV) - 1; i >= 0; i--) begin
      if (mgmt_adr[SEL_LSB +: SEL_W] == SLV_ID[i*SEL_W +: SEL_W]) begin
        any_hit = 1'b1;
        hit_idx = SIDX_W'(i);
      end
    end
  end

`ifdef MGMT_HUB_TIMEOUT_EN
  logic [TMO_W-1:0] cnt_q, cnt_d;

  assign tmo_hit = (cnt_q == TMO_W'(TIMEOUT));

  // Counts cycles of an unacked held request in IDLE, or cycles without rxe in WAIT_RXD.
  // Any other case (ack, rxe, timeout, idle bus) restarts it from zero.
  always_comb begin
    cnt_d = '0;
    if (!tmo_hit &&
        ((state_q == StIdle && mgmt_req && any_hit && !slv_ack[hit_idx]) ||
         (state_q == StWaitRxd && !slv_rxe[sel_q]))) begin
      cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    rwn_d    = rwn_q;
    rxe_d    = 1'b0;
    rxd_d    = rxd_q;
    slv_req  = '0;
    mgmt_ack = 1'b0;
    rxe_ok   = '0;
    set_dec  = 1'b0;
    set_tmo  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (mgmt_req) begin
          rwn_d = mgmt_rwn;
          if (!any_hit) begin
            state_d = StErrRsp;
            set_dec = 1'b1;
          end else if (tmo_hit) begin
            // slv_req stays low this cycle so a late ack cannot complete the transfer.
            state_d = StErrRsp;
            set_tmo = 1'b1;
          end else begin
            sel_d            = hit_idx;
            slv_req[hit_idx] = 1'b1;
            mgmt_ack         = slv_ack[hit_idx];
            if (slv_ack[hit_idx] && mgmt_rwn) begin
              if (slv_rxe[hit_idx]) begin
                // Zero-latency read: rxe together with ack completes the transfer.
                rxe_ok[hit_idx] = 1'b1;
                rxe_d           = 1'b1;
                rxd_d           = slv_rxd[32*int'(hit_idx) +: 32];
              end else begin
                state_d = StWaitRxd;
              end
            end
          end
        end
      end
      StWaitRxd: begin
        if (slv_rxe[sel_q]) begin
          rxe_ok[sel_q] = 1'b1;
          rxe_d         = 1'b1;
          rxd_d         = slv_rxd[32*int'(sel_q) +: 32];
          state_d       = StIdle;
        end else if (tmo_hit) begin
          rxe_d   = 1'b1;
          rxd_d   = ERR_DATA;
          set_tmo = 1'b1;
          state_d = StIdle;
        end
      end
      StErrRsp: begin
        mgmt_ack = 1'b1;
        if (rwn_q) begin
          rxe_d = 1'b1;
          rxd_d = ERR_DATA;
        end
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Requests and acks are cut off as soon as reset is applied, not at the next edge.
    if (!rstn) begin
      slv_req  = '0;
      mgmt_ack = 1'b0;
    end

    // A new error in the same cycle as err_clr wins.
    err_d = (err_q & ~{3{err_clr}}) | {|(slv_rxe & ~rxe_ok), set_tmo, set_dec};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StIdle;
      sel_q   <= '0;
      rwn_q   <= 1'b0;
      rxe_q   <= 1'b0;
      rxd_q   <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      rwn_q   <= rwn_d;
      rxe_q   <= rxe_d;
      rxd_q   <= rxd_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_mgmt_hub.sv
module tb_mgmt_hub;

  localparam int N = 5;

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic            mgmt_req;
  logic [31:0]     mgmt_adr;
  logic            mgmt_rwn;
  logic [1:0]      mgmt_wen;
  logic [31:0]     mgmt_txd;
  logic            mgmt_ack;
  logic            mgmt_rxe;
  logic [31:0]     mgmt_rxd;
  logic [N-1:0]    slv_req;
  logic [31:0]     slv_adr;
  logic            slv_rwn;
  logic [1:0]      slv_wen;
  logic [31:0]     slv_txd;
  logic [N-1:0]    slv_ack;
  logic [N-1:0]    slv_rxe;
  logic [N*32-1:0] slv_rxd;
  logic [2:0]      err_stat;
  logic            err_clr;

  mgmt_hub #(
    .N_SLV    (N),
    .SEL_LSB  (12),
    .SEL_W    (4),
    .SLV_ID   (20'h43210),
    .TMO_W    (8),
    .TIMEOUT  (8),
    .ERR_DATA (32'hDEADBEEF)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .mgmt_req (mgmt_req),
    .mgmt_adr (mgmt_adr),
    .mgmt_rwn (mgmt_rwn),
    .mgmt_wen (mgmt_wen),
    .mgmt_txd (mgmt_txd),
    .mgmt_ack (mgmt_ack),
    .mgmt_rxe (mgmt_rxe),
    .mgmt_rxd (mgmt_rxd),
    .slv_req  (slv_req),
    .slv_adr  (slv_adr),
    .slv_rwn  (slv_rwn),
    .slv_wen  (slv_wen),
    .slv_txd  (slv_txd),
    .slv_ack  (slv_ack),
    .slv_rxe  (slv_rxe),
    .slv_rxd  (slv_rxd),
    .err_stat (err_stat),
    .err_clr  (err_clr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [31:0] data;
  } exp_t;

  exp_t ack_q[$];
  exp_t rxe_q[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic exp_ack(input int c);
    ack_q.push_back('{cyc: c, data: 32'h0});
  endtask

  task automatic exp_rxe(input int c, input logic [31:0] d);
    rxe_q.push_back('{cyc: c, data: d});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every ack / rxe pulse the DUT presents is matched against the scoreboard.
  always @(negedge clk) begin
    if (mgmt_ack === 1'b1) begin
      n_vec++;
      if (ack_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_ack: ack at cycle %0d, none expected", cyc);
      end else begin
        mon_e = ack_q.pop_front();
        if (mon_e.cyc != cyc) begin
          n_err++;
          $display("FAIL ack_cycle: ack at cycle %0d, expected cycle %0d", cyc, mon_e.cyc);
        end
      end
    end
    if (mgmt_rxe === 1'b1) begin
      n_vec++;
      if (rxe_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_rxe: rxe at cycle %0d data %h", cyc, mgmt_rxd);
      end else begin
        mon_e = rxe_q.pop_front();
        if (mon_e.cyc != cyc || mon_e.data !== mgmt_rxd) begin
          n_err++;
          $display("FAIL rxe_resp: got cycle %0d data %h, expected cycle %0d data %h",
                   cyc, mgmt_rxd, mon_e.cyc, mon_e.data);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int t0;

  initial begin
    mgmt_req = 1'b0;
    mgmt_adr = '0;
    mgmt_rwn = 1'b0;
    mgmt_wen = 2'b00;
    mgmt_txd = '0;
    slv_ack  = '0;
    slv_rxe  = '0;
    slv_rxd  = '0;
    err_clr  = 1'b0;

    // Reset state
    tick();
    tick();
    chk("rst_slv_req", 32'(slv_req), 32'h0);
    chk("rst_mgmt_rxe", 32'(mgmt_rxe), 32'h0);
    chk("rst_mgmt_rxd", mgmt_rxd, 32'h0);
    chk("rst_err_stat", 32'(err_stat), 32'h0);
    rstn = 1'b1;

    // Write to slave 1, ack after 3 wait cycles
    tick();
    t0 = cyc;
    mgmt_req = 1'b1; mgmt_rwn = 1'b0; mgmt_adr = 32'h0000_1004;
    mgmt_wen = 2'b11; mgmt_txd = 32'h0BAD_F00D;
    exp_ack(t0 + 3);
    #1 chk("wr_slv_adr", slv_adr, 32'h0000_1004);
    chk("wr_slv_txd", slv_txd, 32'h0BAD_F00D);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) tick();
      if (k == 3) slv_ack[1] = 1'b1;
      #1 chk("wr_slv_req", 32'(slv_req), 32'h02);
    end
    tick();
    mgmt_req = 1'b0; slv_ack = '0;
    #1 chk("wr_done_slv_req", 32'(slv_req), 32'h0);

    // Read slave 2 with a second request stalled behind it
    tick();
    t0 = cyc;
    mgmt_req = 1'b1; mgmt_rwn = 1'b1; mgmt_adr = 32'h0000_2000;
    #1 chk("rd_slv_req", 32'(slv_req), 32'h04);
    tick();
    slv_ack[2] = 1'b1;
    exp_ack(t0 + 1);
    tick();
    slv_ack = '0;
    mgmt_req = 1'b1; mgmt_rwn = 1'b0; mgmt_adr = 32'h0000_1008;
    #1 chk("rd_stall_c2", 32'(slv_req), 32'h0);
    tick();
    #1 chk("rd_stall_c3", 32'(slv_req), 32'h0);
    tick();
    slv_rxe[2] = 1'b1; slv_rxd[64 +: 32] = 32'h1234_5678;
    exp_rxe(t0 + 5, 32'h1234_5678);
    tick();
    slv_rxe = '0; slv_rxd = '0;
    exp_ack(t0 + 6);
    #1 chk("rd_next_slv_req", 32'(slv_req), 32'h02);
    tick();
    slv_ack[1] = 1'b1;
    tick();
    slv_ack = '0; mgmt_req = 1'b0;
    tick();
    chk("rxd_hold", mgmt_rxd, 32'h1234_5678);

    // Unmapped read
    tick();
    t0 = cyc;
    mgmt_req = 1'b1; mgmt_rwn = 1'b1; mgmt_adr = 32'h0000_F000;
    exp_ack(t0 + 1);
    exp_rxe(t0 + 2, 32'hDEAD_BEEF);
    #1 chk("dec_slv_req", 32'(slv_req), 32'h0);
    tick();
    tick();
    mgmt_req = 1'b0;
    #1 chk("dec_err_stat", 32'(err_stat), 32'h1);

    // Clear, then a stray rxe from slave 3 while slave 0's read is pending, with err_clr
    tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    #1 chk("clr_err_stat", 32'(err_stat), 32'h0);
    tick();
    t0 = cyc;
    mgmt_req = 1'b1; mgmt_rwn = 1'b1; mgmt_adr = 32'h0000_0000; slv_ack[0] = 1'b1;
    exp_ack(t0);
    tick();
    mgmt_req = 1'b0; slv_ack = '0; slv_rxe[3] = 1'b1; err_clr = 1'b1;
    tick();
    slv_rxe = '0; err_clr = 1'b0;
    #1 chk("stray_set_wins", 32'(err_stat), 32'h4);
    slv_rxe[0] = 1'b1; slv_rxd[0 +: 32] = 32'hA5A5_0001;
    exp_rxe(t0 + 3, 32'hA5A5_0001);
    tick();
    slv_rxe = '0;

    // Zero-latency read from slave 4 (ack and rxe together), errors cleared meanwhile
    tick();
    t0 = cyc;
    mgmt_req = 1'b1; mgmt_rwn = 1'b1; mgmt_adr = 32'h0000_4010;
    slv_ack[4] = 1'b1; slv_rxe[4] = 1'b1; slv_rxd[128 +: 32] = 32'hCAFE_0004;
    err_clr = 1'b1;
    exp_ack(t0);
    exp_rxe(t0 + 1, 32'hCAFE_0004);
    tick();
    mgmt_req = 1'b0; slv_ack = '0; slv_rxe = '0; err_clr = 1'b0;
    #1 chk("zlat_no_stray", 32'(err_stat), 32'h0);

    // rxe with no read pending
    tick();
    slv_rxe[1] = 1'b1;
    tick();
    slv_rxe = '0;
    #1 chk("idle_stray", 32'(err_stat), 32'h4);

`ifdef MGMT_HUB_TIMEOUT_EN
    // Silent slave 3: ack timeout
    tick();
    t0 = cyc;
    mgmt_req = 1'b1; mgmt_rwn = 1'b1; mgmt_adr = 32'h0000_3000; err_clr = 1'b1;
    exp_ack(t0 + 9);
    exp_rxe(t0 + 10, 32'hDEAD_BEEF);
    for (int k = 0; k < 9; k++) begin
      if (k > 0) tick();
      if (k == 1) err_clr = 1'b0;
      #1 chk("tmo_slv_req", 32'(slv_req), (k < 8) ? 32'h08 : 32'h0);
    end
    tick();
    tick();
    mgmt_req = 1'b0;
    #1 chk("tmo_err_stat", 32'(err_stat), 32'h2);

    // Slave 1 acks a read but never returns data; its late rxe counts as stray
    tick();
    t0 = cyc;
    mgmt_req = 1'b1; mgmt_rwn = 1'b1; mgmt_adr = 32'h0000_1000; slv_ack[1] = 1'b1;
    exp_ack(t0);
    exp_rxe(t0 + 10, 32'hDEAD_BEEF);
    tick();
    mgmt_req = 1'b0; slv_ack = '0;
    repeat (10) tick();
    slv_rxe[1] = 1'b1;
    tick();
    slv_rxe = '0;
    #1 chk("rxd_tmo_err_stat", 32'(err_stat), 32'h6);
`else
    // Without timeouts the hub waits for a silent slave indefinitely
    tick();
    mgmt_req = 1'b1; mgmt_rwn = 1'b1; mgmt_adr = 32'h0000_3000; err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    repeat (1000) tick();
    chk("notmo_slv_req", 32'(slv_req), 32'h08);
    chk("notmo_err_stat", 32'(err_stat), 32'h0);
    tick();
    mgmt_req = 1'b0;
`endif

    // Reset in the middle of a pending read
    tick();
    t0 = cyc;
    mgmt_req = 1'b1; mgmt_rwn = 1'b1; mgmt_adr = 32'h0000_2000; slv_ack[2] = 1'b1;
    exp_ack(t0);
    tick();
    slv_ack = '0; mgmt_rwn = 1'b0;
    slv_rxe[2] = 1'b1; slv_rxd[64 +: 32] = 32'h7777_0002;
    rstn = 1'b0;
    #1 chk("rst_mid_slv_req", 32'(slv_req), 32'h0);
    chk("rst_mid_rxe", 32'(mgmt_rxe), 32'h0);
    chk("rst_mid_ack", 32'(mgmt_ack), 32'h0);
    chk("rst_mid_err", 32'(err_stat), 32'h0);
    tick();
    slv_rxe = '0; mgmt_req = 1'b0;
    #1 chk("rst_hold_rxe", 32'(mgmt_rxe), 32'h0);
    tick();
    rstn = 1'b1;
    tick();
    mgmt_req = 1'b1; mgmt_rwn = 1'b0; mgmt_adr = 32'h0000_1000; slv_ack[1] = 1'b1;
    exp_ack(cyc);
    tick();
    mgmt_req = 1'b0; slv_ack = '0;
    tick();
    tick();

    chk("ack_queue_empty", 32'(ack_q.size()), 32'h0);
    chk("rxe_queue_empty", 32'(rxe_q.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
